// File: rtl/rec_engine_pkg.sv
// Shared definitions for the recurrence engine: FSM encoding and the
// signed saturation limits for a given data width.
package rec_engine_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int LIM_W = 64;

   function automatic logic signed [LIM_W-1:0] sat_max(input int w);
      sat_max = (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [LIM_W-1:0] sat_min(input int w);
      sat_min = -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/rec_step.sv
// One step of y' = (y << k) + x, evaluated exactly in W+2^KW bits, then
// either clamped or truncated back to W bits.
module rec_step
   import rec_engine_pkg::*;
#(
   parameter int W  = 32,
   parameter int KW = 3
) (
   input  logic [W-1:0]  y,
   input  logic [W-1:0]  x,
   input  logic [KW-1:0] k,
   input  logic          sat,
   output logic [W-1:0]  y_next,
   output logic          ovf
);

   localparam int S = W + (2 ** KW);
   localparam logic signed [S-1:0] S_MAX = S'(sat_max(W));
   localparam logic signed [S-1:0] S_MIN = S'(sat_min(W));

   logic signed [S-1:0] y_ext_s;
   logic signed [S-1:0] x_ext_s;
   logic signed [S-1:0] sum_s;
   logic                hi_s;
   logic                lo_s;

   assign y_ext_s = {{(S - W){y[W-1]}}, y};
   assign x_ext_s = {{(S - W){x[W-1]}}, x};
   assign sum_s   = (y_ext_s <<< k) + x_ext_s;
   assign hi_s    = (sum_s > S_MAX);
   assign lo_s    = (sum_s < S_MIN);

   // Out of range in either direction is an overflow in both modes.
   always_comb begin
      y_next = sum_s[W-1:0];
      ovf    = 1'b0;
      if (hi_s) begin
         ovf = 1'b1;
         if (sat) begin
            y_next = S_MAX[W-1:0];
         end else begin
            y_next = sum_s[W-1:0];
         end
      end else if (lo_s) begin
         ovf = 1'b1;
         if (sat) begin
            y_next = S_MIN[W-1:0];
         end else begin
            y_next = sum_s[W-1:0];
         end
      end else begin
         ovf    = 1'b0;
         y_next = sum_s[W-1:0];
      end
   end

endmodule

// File: rtl/rec_engine.sv
// First-order recurrence engine y(n) = (y(n-1) << k) + x(n) with a
// start/busy/done command handshake and a valid/ready sample stream.
module rec_engine
   import rec_engine_pkg::*;
#(
   parameter int W  = 32,
   parameter int NW = 8,
   parameter int KW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [NW-1:0] n_iter,
   input  logic [KW-1:0] k,
   input  logic          sat,
   input  logic [W-1:0]  y0,
   input  logic [W-1:0]  x,
   input  logic          x_valid,
   output logic          x_ready,
   output logic          busy,
   output logic          done,
   output logic [W-1:0]  y,
   output logic          ovf
);

   state_t        state_r;
   logic [NW-1:0] cnt_r;
   logic [NW-1:0] n_r;
   logic [KW-1:0] k_r;
   logic          sat_r;
   logic [W-1:0]  y_r;
   logic          ovf_r;
   logic          busy_r;
   logic          done_r;
   logic [W-1:0]  step_y_s;
   logic          step_ovf_s;

   rec_step #(
      .W  (W),
      .KW (KW)
   ) u_step (
      .y      (y_r),
      .x      (x),
      .k      (k_r),
      .sat    (sat_r),
      .y_next (step_y_s),
      .ovf    (step_ovf_s)
   );

   // x_ready is a pure state decode so there is no input-to-output path.
   assign x_ready = (state_r == ST_RUN);
   assign busy    = busy_r;
   assign done    = done_r;
   assign y       = y_r;
   assign ovf     = ovf_r;

   // Control FSM, iteration counter, parameter latches and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         n_r     <= '0;
         k_r     <= '0;
         sat_r   <= 1'b0;
         y_r     <= '0;
         ovf_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  n_r    <= n_iter;
                  k_r    <= k;
                  sat_r  <= sat;
                  y_r    <= y0;
                  cnt_r  <= '0;
                  ovf_r  <= 1'b0;
                  busy_r <= 1'b1;
                  if (n_iter == '0) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                  end else begin
                     state_r <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (x_valid) begin
                  y_r   <= step_y_s;
                  ovf_r <= ovf_r | step_ovf_s;
                  cnt_r <= cnt_r + NW'(1);
                  // n_r is at least 1 here, so n_r-1 cannot underflow.
                  if (cnt_r == (n_r - NW'(1))) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/rec_engine.md
# rec_engine

Parametrised first-order recurrence engine computing y(n) = (y(n-1) << k) + x(n) over a programmable number of iterations. It has a start/busy/done command handshake, a valid/ready input stream for x, a selectable wrap or saturate overflow mode, and a sticky overflow flag. It sits between a sample source and a register-mapped control interface, and replaces fixed-gain, fixed-count iterators.

## Interface
- W, 32: data width of x, y0 and y (two's complement, signed)
- NW, 8: width of the iteration-count field
- KW, 3: width of the shift (gain = 2^k) field; k ranges 0..2^KW-1
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  command pulse; accepted only in IDLE
- n_iter  in  NW  iteration count, sampled on accepted start
- k  in  KW  shift amount, sampled on accepted start
- sat  in  1  1 = saturate, 0 = wrap; sampled on accepted start
- y0  in  W  initial value, sampled on accepted start
- x  in  W  input sample
- x_valid  in  1  x is valid this cycle
- x_ready  out  1  engine accepts x this cycle (high only in RUN)
- busy  out  1  high in RUN and DONE
- done  out  1  single-cycle pulse, final y valid
- y  out  W  registered result; holds after DONE until the next accepted start
- ovf  out  1  sticky overflow flag, cleared on accepted start

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1, latch n_iter, k, sat; set y<=y0, cnt<=0, ovf<=0.
  - Go to RUN, or to DONE if n_iter==0.
- RUN:
  - x_ready=1. A transfer occurs when x_valid=1.
  - On each transfer: y <= f(y, x); cnt <= cnt+1.
  - A transfer with cnt==n_iter-1 moves the engine to DONE.
  - With no transfer, all state holds.
- DONE: done=1 for exactly one cycle, then IDLE.
- Step f:
  - Compute s = (sign-extended y << k) + sign-extended x in W+2^KW bits, signed. This range is exact, so there is no intermediate loss.
  - sat=1: if s > 2^(W-1)-1, result is 0x7FF..F; if s < -2^(W-1), result is 0x800..0. Set ovf on clamp.
  - sat=0: result is s[W-1:0]. Set ovf if the truncation changed the value.
- start outside IDLE is ignored; latched parameters do not change mid-run.
- n_iter=2^NW-1 is legal; cnt is NW bits and never wraps.
- Reset values: y=0, ovf=0, done=0, busy=0, x_ready=0, state=IDLE, cnt=0.
- Reset mid-run aborts immediately. There is no done pulse, and the partial y is lost.

## Timing
- Start accepted at edge 0: y=y0 and busy=1 from edge 0.
- With x_valid held high, transfers occur at edges 1..N. y after edge i equals the i-th result.
- done=1 in the cycle following edge N; state is IDLE after edge N+1.
- Latency from start to done is N+1 cycles plus the number of stall cycles (x_valid=0 in RUN).
- n_iter=0: done is high in the cycle after the start edge, with y=y0.
- start may be asserted in the done cycle, but it is ignored. The earliest accepted start is in the cycle after done.
- All outputs are registered except x_ready, which decodes state only and has no combinational path from inputs.

## Structure
- Shared package (rec_engine_pkg) holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - the saturation limit constants as functions of W
- The top holds the FSM, the counter, the parameter latches, the y register and the ovf register.
- Sub-module rec_step is purely combinational: inputs y, x, k, sat; outputs next y and overflow. It is instantiated once.

## Test plan
- Basic, wrap: W=32, k=1, sat=0, y0=0, x=1, n=4, x_valid=1 → y=1,3,7,15 at edges 1–4; done in cycle 5; ovf=0.
- Signed: k=2, y0=-1, x=-3, n=2 → y=-7 then -31; ovf=0.
- Overflow, both modes:
  - y0=0x40000000, k=1, x=0, n=1, sat=1 → y=0x7FFFFFFF, ovf=1.
  - Same stimulus with sat=0 → y=0x80000000, ovf=1.
  - On the next start, ovf clears to 0.
- Stall: k=1, y0=0, x=1, n=3, x_valid low for 2 cycles after the first transfer → y=7; done 2 cycles later than unstalled; y holds during the stall.
- Edge cases:
  - n=0, y0=0x1234 → done one cycle after start, y=0x1234.
  - start pulsed during RUN → ignored, result unchanged.
- Reset mid-run: rst low at edge 2 of n=10 → immediately busy=0, y=0, x_ready=0, no done pulse. A new start after rst release runs normally.
